// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared types and constants for the LED show scheduler:
//                FSM state encoding, playlist geometry and entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int N_SLOTS = 4;
    localparam int SLOT_W  = 2;
    localparam int MODE_W  = 2;
    localparam int DWELL_W = 8;
    // One extra bit so a stored dwell of 0 can be loaded as 256 ticks.
    localparam int DCNT_W  = DWELL_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PLAY       = 2'd1,
        ST_WAIT_FRAME = 2'd2,
        ST_OVERRIDE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [MODE_W-1:0]  mode;
        logic [DWELL_W-1:0] dwell;
    } entry_t;

    // Stored dwell of 0 means the full 256-tick dwell.
    function automatic logic [DCNT_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DCNT_W'(256) : DCNT_W'(d);
    endfunction

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_tick_gen
//  Description : Prescaler counting 0..TICK_DIV-1 while enabled; emits a
//                one-cycle tick on the terminal count. clr forces it to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick = en && !clr && (count_q == CNT_W'(TICK_DIV - 1));

    // Next prescaler value: clear wins, wrap on terminal count.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tick ? '0 : count_q + CNT_W'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : led_tick_gen
`default_nettype wire

// File: rtl/led_show_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : led_show_scheduler
//  Description : Steps a 4-slot playlist of animation modes, switching only
//                at animation frame boundaries, with a manual override path
//                and a one-cycle restart pulse to the animation core.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_show_scheduler
    import led_pkg::*;
#(
    parameter int          TICK_DIV  = 50000,
    parameter logic [7:0]  DWELL_RST = 8'd16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              frame_done,
    input  logic              cfg_we,
    input  logic [SLOT_W-1:0] cfg_addr,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic              ovr_req,
    input  logic [MODE_W-1:0] ovr_mode,
    output logic [MODE_W-1:0] mode,
    output logic              anim_rst,
    output logic [SLOT_W-1:0] slot,
    output logic              ovr_ack
);

    state_t              state_q,    state_d;
    logic [MODE_W-1:0]   mode_q,     mode_d;
    logic [SLOT_W-1:0]   slot_q,     slot_d;
    logic [DCNT_W-1:0]   dwell_q,    dwell_d;
    logic                anim_rst_q, anim_rst_d;
    logic                ovr_ack_q,  ovr_ack_d;
    entry_t              playlist_q [N_SLOTS];
    entry_t              playlist_d [N_SLOTS];

    logic                anim_req;
    logic                tick_clr;
    logic                tick_en;
    logic                tick;
    logic [SLOT_W-1:0]   next_slot;
    entry_t              cur_entry;
    entry_t              next_entry;

    assign next_slot  = slot_q + SLOT_W'(1);
    assign cur_entry  = playlist_q[slot_q];
    assign next_entry = playlist_q[next_slot];

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .en   (tick_en),
        .tick (tick)
    );

    // Playlist write port; reads elsewhere see the old entry until the next edge.
    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) begin
            playlist_d[i] = playlist_q[i];
        end
        if (cfg_we) begin
            playlist_d[cfg_addr] = '{mode: cfg_mode, dwell: cfg_dwell};
        end
    end

    // Scheduler FSM: next state, mode/slot/dwell updates and restart request.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        slot_d   = slot_q;
        dwell_d  = dwell_q;
        anim_req = 1'b0;
        tick_clr = 1'b1;
        tick_en  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ovr_req) begin
                    state_d  = ST_OVERRIDE;
                    mode_d   = ovr_mode;
                    anim_req = 1'b1;
                end else if (run) begin
                    state_d = ST_PLAY;
                    dwell_d = dwell_load(cur_entry.dwell);
                end
            end

            ST_PLAY: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (frame_done && ovr_req) begin
                    // Override takes the frame boundary even if dwell expires now.
                    state_d  = ST_OVERRIDE;
                    mode_d   = ovr_mode;
                    anim_req = 1'b1;
                end else begin
                    tick_clr = 1'b0;
                    tick_en  = 1'b1;
                    if (tick) begin
                        dwell_d = dwell_q - DCNT_W'(1);
                        if (dwell_q == DCNT_W'(1)) begin
                            state_d = ST_WAIT_FRAME;
                        end
                    end
                end
            end

            ST_WAIT_FRAME: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (frame_done) begin
                    anim_req = 1'b1;
                    if (ovr_req) begin
                        state_d = ST_OVERRIDE;
                        mode_d  = ovr_mode;
                    end else begin
                        state_d = ST_PLAY;
                        slot_d  = next_slot;
                        mode_d  = next_entry.mode;
                        dwell_d = dwell_load(next_entry.dwell);
                    end
                end
            end

            ST_OVERRIDE: begin
                if (!ovr_req) begin
                    state_d  = run ? ST_PLAY : ST_IDLE;
                    mode_d   = cur_entry.mode;
                    dwell_d  = dwell_load(cur_entry.dwell);
                    anim_req = 1'b1;
                end else begin
                    mode_d   = ovr_mode;
                    anim_req = (ovr_mode != mode_q);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Back-to-back restarts only when the mode really changes again.
        anim_rst_d = anim_req && !(anim_rst_q && (mode_d == mode_q));
        ovr_ack_d  = (state_d == ST_OVERRIDE);
    end

    // State and playlist registers; reset dominates any concurrent write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= '0;
            slot_q     <= '0;
            dwell_q    <= '0;
            anim_rst_q <= 1'b0;
            ovr_ack_q  <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) begin
                playlist_q[i] <= '{mode: MODE_W'(i), dwell: DWELL_RST};
            end
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            slot_q     <= slot_d;
            dwell_q    <= dwell_d;
            anim_rst_q <= anim_rst_d;
            ovr_ack_q  <= ovr_ack_d;
            for (int i = 0; i < N_SLOTS; i++) begin
                playlist_q[i] <= playlist_d[i];
            end
        end
    end

    assign mode     = mode_q;
    assign anim_rst = anim_rst_q;
    assign slot     = slot_q;
    assign ovr_ack  = ovr_ack_q;

endmodule : led_show_scheduler
`default_nettype wire

// File: tb/tb_led_show_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_show_scheduler
//  Description : Directed self-checking bench for led_show_scheduler with
//                TICK_DIV=4, DWELL_RST=2 (8 cycles per default dwell).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_show_scheduler;

    localparam int TICK_DIV  = 4;
    localparam int DWELL_CYC = 2 * TICK_DIV;

    typedef struct {
        string      tag;
        logic [5:0] val;   // {mode, slot, anim_rst, ovr_ack}
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       frame_done = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [1:0] cfg_mode = '0;
    logic [7:0] cfg_dwell = '0;
    logic       ovr_req = 1'b0;
    logic [1:0] ovr_mode = '0;
    logic [1:0] mode;
    logic       anim_rst;
    logic [1:0] slot;
    logic       ovr_ack;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    led_show_scheduler #(
        .TICK_DIV  (TICK_DIV),
        .DWELL_RST (8'd2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .frame_done (frame_done),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_mode   (cfg_mode),
        .cfg_dwell  (cfg_dwell),
        .ovr_req    (ovr_req),
        .ovr_mode   (ovr_mode),
        .mode       (mode),
        .anim_rst   (anim_rst),
        .slot       (slot),
        .ovr_ack    (ovr_ack)
    );

    always #5 clk = ~clk;

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic compare_front();
        exp_t       e;
        logic [5:0] obs;
        e   = sb.pop_front();
        obs = {mode, slot, anim_rst, ovr_ack};
        checks++;
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed mode/slot/anim/ack=%b expected %b", e.tag, obs, e.val);
        end
    endtask

    // Push the expected outputs for the inputs just driven, clock once, check.
    task automatic step(input string tag, input logic [1:0] m, input logic [1:0] s,
                        input logic a, input logic k);
        exp_t e;
        e.tag = tag;
        e.val = {m, s, a, k};
        sb.push_back(e);
        tick_n(1);
        compare_front();
    endtask

    // Let a slot run its dwell, show frame_done is ignored at the expiry edge
    // and honoured one edge later.
    task automatic play_through(input string tag, input int cyc,
                                input logic [1:0] cm, input logic [1:0] cs,
                                input logic [1:0] nm, input logic [1:0] ns);
        tick_n(cyc - 1);
        frame_done = 1'b1;
        step({tag, "_hold"},   cm, cs, 1'b0, 1'b0);
        step({tag, "_switch"}, nm, ns, 1'b1, 1'b0);
        frame_done = 1'b0;
    endtask

    initial begin
        tick_n(2);
        sb.push_back('{tag: "reset", val: 6'b00_00_0_0});
        compare_front();
        rst = 1'b0;

        // IDLE -> PLAY; an early frame_done must not switch.
        run = 1'b1;
        step("idle_to_play", 2'd0, 2'd0, 1'b0, 1'b0);
        tick_n(3);
        frame_done = 1'b1;
        step("early_frame", 2'd0, 2'd0, 1'b0, 1'b0);
        frame_done = 1'b0;
        tick_n(7);
        frame_done = 1'b1;
        step("switch_1", 2'd1, 2'd1, 1'b1, 1'b0);
        frame_done = 1'b0;
        step("anim_one_cycle", 2'd1, 2'd1, 1'b0, 1'b0);

        // Rewrite slot 1 to dwell 0 (=256) while it is playing.
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_mode = 2'd1; cfg_dwell = 8'd0;
        step("cfg_no_effect", 2'd1, 2'd1, 1'b0, 1'b0);
        cfg_we = 1'b0;
        tick_n(DWELL_CYC - 2);
        frame_done = 1'b1;
        step("switch_2", 2'd2, 2'd2, 1'b1, 1'b0);
        frame_done = 1'b0;

        play_through("s2_s3",  DWELL_CYC, 2'd2, 2'd2, 2'd3, 2'd3);
        play_through("wrap",   DWELL_CYC, 2'd3, 2'd3, 2'd0, 2'd0);
        play_through("s0_s1",  DWELL_CYC, 2'd0, 2'd0, 2'd1, 2'd1);
        play_through("long",   256 * TICK_DIV, 2'd1, 2'd1, 2'd2, 2'd2);

        // Override requested on the very frame_done where slot 2 expires.
        tick_n(DWELL_CYC - 1);
        ovr_req = 1'b1; ovr_mode = 2'd3; frame_done = 1'b1;
        step("ovr_enter", 2'd3, 2'd2, 1'b1, 1'b1);
        frame_done = 1'b0;
        step("ovr_hold", 2'd3, 2'd2, 1'b0, 1'b1);
        ovr_mode = 2'd1;
        step("ovr_track", 2'd1, 2'd2, 1'b1, 1'b1);
        step("ovr_track_hold", 2'd1, 2'd2, 1'b0, 1'b1);
        ovr_req = 1'b0;
        step("ovr_exit", 2'd2, 2'd2, 1'b1, 1'b0);

        // From PLAY the override waits for a frame boundary.
        ovr_req = 1'b1; ovr_mode = 2'd0;
        step("ovr_wait_frame", 2'd2, 2'd2, 1'b0, 1'b0);
        frame_done = 1'b1;
        step("ovr_enter_play", 2'd0, 2'd2, 1'b1, 1'b1);
        frame_done = 1'b0;
        ovr_req = 1'b0;
        step("ovr_exit2", 2'd2, 2'd2, 1'b1, 1'b0);

        // Pause after one tick has been consumed; resume restarts the full dwell.
        tick_n(5);
        run = 1'b0;
        step("run_off", 2'd2, 2'd2, 1'b0, 1'b0);
        tick_n(4);
        step("idle_hold", 2'd2, 2'd2, 1'b0, 1'b0);
        run = 1'b1;
        step("resume", 2'd2, 2'd2, 1'b0, 1'b0);
        play_through("resume", DWELL_CYC, 2'd2, 2'd2, 2'd3, 2'd3);

        // Override from IDLE, then reset while overriding; reset beats cfg_we.
        run = 1'b0;
        step("idle_again", 2'd3, 2'd3, 1'b0, 1'b0);
        ovr_req = 1'b1; ovr_mode = 2'd2;
        step("ovr_from_idle", 2'd2, 2'd3, 1'b1, 1'b1);
        rst = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_mode = 2'd3; cfg_dwell = 8'd5;
        step("rst_in_ovr", 2'd0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0; cfg_we = 1'b0; ovr_req = 1'b0;
        step("post_rst", 2'd0, 2'd0, 1'b0, 1'b0);
        ovr_req = 1'b1; ovr_mode = 2'd1;
        step("ovr_idle2", 2'd1, 2'd0, 1'b1, 1'b1);
        ovr_req = 1'b0;
        step("rst_beats_cfg", 2'd0, 2'd0, 1'b1, 1'b0);
        step("idle_after_ovr", 2'd0, 2'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_led_show_scheduler
`default_nettype wire
